dual_edge_write_arbiter: RTL and testbench

DUAL_EDGE_WRITE_ARBITER -- requirements
Module: dual_edge_write_arbiter

---
 rtl/dual_edge_write_arbiter.sv | 119 +++++++++++
 tb/tb_dual_edge_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_edge_write_arbiter.sv
// Two-requester round-robin write arbiter driving an 8-bit dual-edge register input.
// Define WR_COUNT_EN to add the wr_cnt completed-write counter port.
module dual_edge_write_arbiter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] D,
  output logic       busy
`ifdef WR_COUNT_EN
  ,
  output logic [7:0] wr_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Last HOLD count value; HOLD is skipped entirely when HOLD_CYCLES is 1.
  localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES > 1) ? 4'(HOLD_CYCLES - 2) : 4'd0;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;   // 0: requester 0 holds the bus, 1: requester 1
  logic       last;               // requester served by the most recent ACK
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic       req0_q, req1_q;
  logic       owner_req;
  logic       busy_nxt;

  assign owner_req = owner ? req1 : req0;
  assign busy_nxt  = (state_nxt != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    owner_nxt    = owner;
    hold_cnt_nxt = 4'd0;
    unique case (state)
      IDLE: begin
        if (req0_q || req1_q) begin
          state_nxt = GRANT;
          if (req0_q && req1_q) owner_nxt = ~last;
          else                  owner_nxt = req1_q;
        end
      end
      GRANT: begin
        if (!owner_req)            state_nxt = IDLE;
        else if (HOLD_CYCLES == 1) state_nxt = ACK;
        else                       state_nxt = HOLD;
      end
      HOLD: begin
        if (!owner_req)                state_nxt = IDLE;
        else if (hold_cnt == HOLD_LAST) state_nxt = ACK;
        else                           hold_cnt_nxt = hold_cnt + 4'd1;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Requests are only sampled while idle, so a held request after ACK
  // sees one clean IDLE cycle before it is arbitrated again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req0_q <= 1'b0;
      req1_q <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      D      <= 8'h00;
    end else begin
      req0_q <= (state == IDLE) && req0;
      req1_q <= (state == IDLE) && req1;
      if (state == ACK) last <= owner;
      gnt0   <= busy_nxt && !owner_nxt;
      gnt1   <= busy_nxt && owner_nxt;
      ack0   <= (state_nxt == ACK) && !owner_nxt;
      ack1   <= (state_nxt == ACK) && owner_nxt;
      busy   <= busy_nxt;
      if (state == IDLE && state_nxt == GRANT) D <= owner_nxt ? data1 : data0;
    end
  end

`ifdef WR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                   wr_cnt <= 8'h00;
    else if (state_nxt == ACK)  wr_cnt <= wr_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_dual_edge_write_arbiter.sv
// Scoreboard bench for dual_edge_write_arbiter: HOLD_CYCLES=2 main instance plus a
// HOLD_CYCLES=1 instance for back-to-back timing; wr_cnt checks need WR_COUNT_EN.
module tb_dual_edge_write_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, ack0, ack1, busy;
  logic [7:0] D;
  logic       h1_req0, h1_req1;
  logic [7:0] h1_data0, h1_data1;
  logic       h1_gnt0, h1_gnt1, h1_ack0, h1_ack1, h1_busy;
  logic [7:0] h1_d;
`ifdef WR_COUNT_EN
  logic [7:0] wr_cnt, h1_wr_cnt;
`endif

  always #5 clk = ~clk;

  dual_edge_write_arbiter #(.HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .D(D), .busy(busy)
`ifdef WR_COUNT_EN
    , .wr_cnt(wr_cnt)
`endif
  );

  dual_edge_write_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .req0(h1_req0), .data0(h1_data0), .req1(h1_req1), .data1(h1_data1),
    .gnt0(h1_gnt0), .gnt1(h1_gnt1), .ack0(h1_ack0), .ack1(h1_ack1), .D(h1_d), .busy(h1_busy)
`ifdef WR_COUNT_EN
    , .wr_cnt(h1_wr_cnt)
`endif
  );

  typedef struct packed {
    logic       who;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic who, input logic [7:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    sb.push_back(e);
  endtask

  // Scoreboard side: every ack must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (gnt0 || gnt1) begin
      check("gnt_onehot", gnt0 && gnt1, 1'b0);
      check("busy_with_gnt", busy, 1'b1);
    end
    if (ack0 || ack1) begin
      check("ack_onehot", ack0 && ack1, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_ack", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("ack_who", ack1, e.who);
        check("ack_data", D, e.data);
        check("ack_gnt_high", ack1 ? gnt1 : gnt0, 1'b1);
      end
    end
  end

  task automatic wait_gnt(input logic who, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((who ? gnt1 : gnt0) !== 1'b1) && cyc < 40);
    if (cyc >= 40) check("gnt_timeout", who ? gnt1 : gnt0, 1'b1);
  endtask

  task automatic wait_ack(input logic who, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((who ? ack1 : ack0) !== 1'b1) && cyc < 40);
    if (cyc >= 40) check("ack_timeout", who ? ack1 : ack0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {gnt0, gnt1, ack0, ack1, busy}, 5'b0);
    check("rst_D", D, 8'h00);
`ifdef WR_COUNT_EN
    check("rst_wr_cnt", wr_cnt, 8'h00);
`endif
    rst = 1'b1;
  endtask

  // Requester 1 is granted, then drops req during HOLD; no ack may follow.
  task automatic abort1();
    int c;
    @(negedge clk);
    req1  = 1'b1;
    data1 = 8'h0F;
    wait_gnt(1'b1, c);
    @(negedge clk);
    check("abort_in_hold_gnt", gnt1, 1'b1);
    req1 = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {gnt0, gnt1, ack0, ack1, busy}, 5'b0);
    check("abort_D_kept", D, 8'h0F);
    repeat (3) @(negedge clk);
    data1 = 8'hFF;
  endtask

  initial begin
    int c;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    h1_req0 = 1'b0; h1_req1 = 1'b0; h1_data0 = 8'h00; h1_data1 = 8'h00;
    do_reset();

    // Single write, latency, data change and a between-edge reset glitch ignored.
    @(negedge clk);
    req0 = 1'b1; data0 = 8'h55;
    expect_wr(1'b0, 8'h55);
    wait_gnt(1'b0, c);
    check("t1_gnt_lat", c, 2);
    check("t1_D", D, 8'h55);
    check("t1_busy", busy, 1'b1);
    data0 = 8'h99;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    wait_ack(1'b0, c);
    check("t1_ack_lat", c, 2);
    req0 = 1'b0;
    @(negedge clk);
    check("t1_idle", {gnt0, ack0, busy}, 3'b0);
    repeat (3) @(negedge clk);

    // Both requesting from reset: grants alternate 0,1,0.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hAA; data1 = 8'hFF;
    expect_wr(1'b0, 8'hAA);
    expect_wr(1'b1, 8'hFF);
    expect_wr(1'b0, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      wait_ack(i[0], c);
      if (i == 0) check("t2_first_ack_lat", c, 4);
      else        check("t2_ack_period", c, 5);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Abort leaves the pointer alone: last served is 0, so 1 wins next.
    abort1();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hAA;
    expect_wr(1'b1, 8'hFF);
    wait_ack(1'b1, c);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Last served is now 1; after an abort of 1 the next tie goes to 0.
    abort1();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    expect_wr(1'b0, 8'hAA);
    wait_ack(1'b0, c);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during HOLD aborts without ack.
    @(negedge clk);
    req0 = 1'b1; data0 = 8'h3C;
    wait_gnt(1'b0, c);
    check("t4_gnt_lat", c, 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4_ctrl", {gnt0, gnt1, ack0, ack1, busy}, 5'b0);
    check("t4_D", D, 8'h00);
    rst  = 1'b1;
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_still_idle", {gnt0, busy}, 2'b0);

`ifdef WR_COUNT_EN
    // 257 completed writes wrap the counter to 1; an abort does not count.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; data0 = 8'h5A;
    for (int i = 0; i < 257; i++) expect_wr(1'b0, 8'h5A);
    for (int i = 0; i < 257; i++) begin
      wait_ack(1'b0, c);
      if (i == 255) begin
        @(negedge clk);
        check("wr_cnt_wrap", wr_cnt, 8'h00);
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    check("wr_cnt_257", wr_cnt, 8'h01);
    abort1();
    check("wr_cnt_abort", wr_cnt, 8'h01);
`endif

    // HOLD_CYCLES=1 instance, continuous req0: ack one cycle after gnt, period 4.
    begin
      int   t;
      int   g_t[$];
      int   a_t[$];
      logic pg;
      t  = 0;
      pg = 1'b0;
      @(negedge clk);
      h1_req0 = 1'b1; h1_data0 = 8'hC3;
      while (a_t.size() < 3 && t < 100) begin
        @(negedge clk);
        t++;
        if (h1_gnt0 && !pg) g_t.push_back(t);
        if (h1_ack0) begin
          a_t.push_back(t);
          check("h1_D", h1_d, 8'hC3);
        end
        pg = h1_gnt0;
      end
      h1_req0 = 1'b0;
      check("h1_ack_count", a_t.size(), 3);
      for (int k = 0; k < a_t.size() && k < g_t.size(); k++) begin
        check("h1_ack_lat", a_t[k] - g_t[k], 1);
        if (k > 0) check("h1_period", g_t[k] - g_t[k-1], 4);
      end
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
